// File: rtl/block_checker_nested_pkg.sv
// Shared encodings for the begin/end nesting checker: FSM states, pending
// counter effect and the ASCII codes the keyword chains compare against.
package block_checker_nested_pkg;

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_WORD  = 4'd1,
    S_B     = 4'd2,
    S_BE    = 4'd3,
    S_BEG   = 4'd4,
    S_BEGI  = 4'd5,
    S_BEGIN = 4'd6,
    S_E     = 4'd7,
    S_EN    = 4'd8,
    S_END   = 4'd9
  } state_e;

  typedef enum logic [1:0] {
    P_NONE = 2'd0,
    P_INC  = 2'd1,
    P_DEC  = 2'd2
  } pend_e;

  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_B     = 8'h62;
  localparam logic [7:0] CH_E     = 8'h65;
  localparam logic [7:0] CH_G     = 8'h67;
  localparam logic [7:0] CH_I     = 8'h69;
  localparam logic [7:0] CH_N     = 8'h6e;
  localparam logic [7:0] CH_D     = 8'h64;

endpackage

// File: rtl/block_checker_nested_char_classifier.sv
// Combinational character classification: letter / word separator, plus the
// case-folded code used for keyword matching.
module char_classifier
  import block_checker_nested_pkg::*;
#(
  parameter bit CASE_INSENSITIVE = 1'b1,
  parameter bit SEP_ANY          = 1'b0
) (
  input  logic [7:0] ch_i,
  output logic       is_letter_o,
  output logic       is_sep_o,
  output logic [7:0] folded_o
);

  logic upper, lower;

  assign upper       = (ch_i >= 8'h41) && (ch_i <= 8'h5a);
  assign lower       = (ch_i >= 8'h61) && (ch_i <= 8'h7a);
  assign is_letter_o = upper || lower;
  // Non-letters other than space only split words in SEP_ANY mode.
  assign is_sep_o    = (ch_i == CH_SPACE) || (SEP_ANY && !is_letter_o);
  assign folded_o    = (CASE_INSENSITIVE && upper) ? (ch_i | 8'h20) : ch_i;

endmodule

// File: rtl/block_checker_nested.sv
// Streaming begin/end balance checker: a keyword FSM plus a signed balance
// counter with provisional (revocable) token effects and sticky overflow.
module block_checker_nested
  import block_checker_nested_pkg::*;
#(
  parameter int DEPTH_W          = 8,
  parameter bit CASE_INSENSITIVE = 1'b1,
  parameter bit SEP_ANY          = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [7:0]         in,
  output logic               result,
  output logic [DEPTH_W-1:0] depth,
  output logic               underflow,
  output logic               overflow
);

  localparam logic signed [DEPTH_W:0] BAL_MAX = {1'b0, {DEPTH_W{1'b1}}};
  localparam logic signed [DEPTH_W:0] BAL_MIN = {1'b1, {DEPTH_W{1'b0}}};
  localparam logic signed [DEPTH_W:0] BAL_ONE = {{DEPTH_W{1'b0}}, 1'b1};

  state_e                    state_q, state_d;
  pend_e                     pend_q, pend_d;
  logic signed [DEPTH_W:0]   bal_q, bal_d;
  logic                      ovf_q, ovf_d;
  logic                      is_letter, is_sep;
  logic [7:0]                ch;

  char_classifier #(
    .CASE_INSENSITIVE (CASE_INSENSITIVE),
    .SEP_ANY          (SEP_ANY)
  ) u_cls (
    .ch_i        (in),
    .is_letter_o (is_letter),
    .is_sep_o    (is_sep),
    .folded_o    (ch)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      pend_q  <= P_NONE;
      bal_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      bal_q   <= bal_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    bal_d   = bal_q;
    ovf_d   = ovf_q;
    if (in_valid) begin
      if (is_sep) begin
        state_d = S_IDLE;
        pend_d  = P_NONE;
      end else if (is_letter) begin
        // Any letter that does not continue a chain falls into WORD.
        state_d = S_WORD;
        pend_d  = P_NONE;
        case (state_q)
          S_IDLE: begin
            if (ch == CH_B && !bal_q[DEPTH_W]) state_d = S_B;
            else if (ch == CH_E)               state_d = S_E;
          end
          S_B:    if (ch == CH_E) state_d = S_BE;
          S_BE:   if (ch == CH_G) state_d = S_BEG;
          S_BEG:  if (ch == CH_I) state_d = S_BEGI;
          S_BEGI: begin
            if (ch == CH_N) begin
              state_d = S_BEGIN;
              if (bal_q != BAL_MAX) begin
                bal_d  = bal_q + BAL_ONE;
                pend_d = P_INC;
              end else begin
                ovf_d  = 1'b1;
              end
            end
          end
          S_E:    if (ch == CH_N) state_d = S_EN;
          S_EN: begin
            if (ch == CH_D) begin
              state_d = S_END;
              if (bal_q != BAL_MIN) begin
                bal_d  = bal_q - BAL_ONE;
                pend_d = P_DEC;
              end
            end
          end
          S_BEGIN, S_END: begin
            // Keyword was only a prefix of a longer word: undo its effect.
            if (pend_q == P_INC)      bal_d = bal_q - BAL_ONE;
            else if (pend_q == P_DEC) bal_d = bal_q + BAL_ONE;
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    result    = (bal_q == '0) && !ovf_q;
    underflow = bal_q[DEPTH_W];
    depth     = bal_q[DEPTH_W] ? '0 : bal_q[DEPTH_W-1:0];
    overflow  = ovf_q;
  end

endmodule

// File: tb/tb_block_checker_nested.sv
// Bench for block_checker_nested: two configurations share one character
// stream; a word-level model predicts every output each cycle.
module tb_block_checker_nested;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_ch = 8'h00;

  logic       res_a, unf_a, ovf_a;
  logic [7:0] dep_a;
  logic       res_b, unf_b, ovf_b;
  logic [1:0] dep_b;

  int n_chk = 0;
  int n_fail = 0;
  bit run = 1'b0;

  // A: DEPTH_W=8, case-insensitive, space-only separators.
  // B: DEPTH_W=2, case-sensitive, any non-letter separates.
  int    mdw[2]  = '{8, 2};
  bit    mci[2]  = '{1'b1, 1'b0};
  bit    msep[2] = '{1'b0, 1'b1};
  int    mbase[2];
  string mw[2];
  bit    movf[2];

  always #5 clk = ~clk;

  block_checker_nested #(.DEPTH_W(8), .CASE_INSENSITIVE(1'b1), .SEP_ANY(1'b0)) dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in(in_ch),
    .result(res_a), .depth(dep_a), .underflow(unf_a), .overflow(ovf_a)
  );

  block_checker_nested #(.DEPTH_W(2), .CASE_INSENSITIVE(1'b0), .SEP_ANY(1'b1)) dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in(in_ch),
    .result(res_b), .depth(dep_b), .underflow(unf_b), .overflow(ovf_b)
  );

  function automatic int mmax(int k);
    return (1 << mdw[k]) - 1;
  endfunction

  function automatic int mmin(int k);
    return -(1 << mdw[k]);
  endfunction

  // Balance = committed base + effect of the word currently being typed.
  function automatic int mbal(int k);
    int e;
    e = 0;
    if (mw[k] == "begin" && mbase[k] >= 0 && mbase[k] < mmax(k)) e = 1;
    else if (mw[k] == "end" && mbase[k] > mmin(k))               e = -1;
    return mbase[k] + e;
  endfunction

  function automatic int e_res(int k);
    return (mbal(k) == 0 && !movf[k]) ? 1 : 0;
  endfunction

  function automatic int e_unf(int k);
    return (mbal(k) < 0) ? 1 : 0;
  endfunction

  function automatic int e_dep(int k);
    return (mbal(k) < 0) ? 0 : mbal(k);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mbase[k] = 0;
      mw[k]    = "";
      movf[k]  = 1'b0;
    end
  endtask

  task automatic step(int k, logic [7:0] c);
    bit         isl, sep;
    logic [7:0] f;
    isl = (c >= 8'h61 && c <= 8'h7a) || (c >= 8'h41 && c <= 8'h5a);
    sep = (c == 8'h20) || (msep[k] && !isl);
    if (sep) begin
      mbase[k] = mbal(k);
      mw[k]    = "";
    end else if (isl) begin
      f     = (mci[k] && c >= 8'h41 && c <= 8'h5a) ? c + 8'h20 : c;
      mw[k] = $sformatf("%s%c", mw[k], f);
      if (mw[k] == "begin" && mbase[k] == mmax(k)) movf[k] = 1'b1;
    end
  endtask

  task automatic cmp(string nm, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic send(logic [7:0] c, bit v = 1'b1);
    in_valid = v;
    in_ch    = c;
    @(posedge clk);
    if (v) for (int k = 0; k < 2; k++) step(k, c);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic sendstr(string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    #2;
    reset = 1'b0;
  endtask

  always @(negedge clk) begin
    if (run) begin
      cmp("A.result",    32'(res_a), e_res(0));
      cmp("A.depth",     32'(dep_a), e_dep(0));
      cmp("A.underflow", 32'(unf_a), e_unf(0));
      cmp("A.overflow",  32'(ovf_a), 32'(movf[0]));
      cmp("B.result",    32'(res_b), e_res(1));
      cmp("B.depth",     32'(dep_b), e_dep(1));
      cmp("B.underflow", 32'(unf_b), e_unf(1));
      cmp("B.overflow",  32'(ovf_b), 32'(movf[1]));
    end
  end

  initial begin
    #1 reset = 1'b1;
    model_reset();
    #1;
    cmp("rst A.result", 32'(res_a), 1);
    cmp("rst A.depth", 32'(dep_a), 0);
    cmp("rst A.underflow", 32'(unf_a), 0);
    cmp("rst A.overflow", 32'(ovf_a), 0);
    cmp("rst B.result", 32'(res_b), 1);
    #10 reset = 1'b0;
    @(negedge clk);
    run = 1'b1;

    // "begin end "
    sendstr("begin");
    cmp("s1 A.depth begin", 32'(dep_a), 1);
    cmp("s1 A.result begin", 32'(res_a), 0);
    cmp("s1 B.depth begin", 32'(dep_b), 1);
    sendstr(" end");
    cmp("s1 A.depth end", 32'(dep_a), 0);
    cmp("s1 A.result end", 32'(res_a), 1);
    send(8'h20);

    // "beginx " revokes; "endx " revokes an underflow
    do_reset();
    sendstr("begin");
    cmp("s2 A.depth n", 32'(dep_a), 1);
    send(8'h78);
    cmp("s2 A.depth x", 32'(dep_a), 0);
    send(8'h20);
    cmp("s2 A.result", 32'(res_a), 1);
    sendstr("end");
    cmp("s2 A.underflow d", 32'(unf_a), 1);
    send(8'h78);
    cmp("s2 A.underflow x", 32'(unf_a), 0);
    cmp("s2 A.result x", 32'(res_a), 1);
    send(8'h20);

    // same stream with idle cycles carrying a junk 'x'
    do_reset();
    begin
      string s;
      s = "beginx ";
      for (int i = 0; i < s.len(); i++) begin
        send(s[i]);
        send(8'h78, 1'b0);
        if (s[i] == 8'h6e) cmp("s3 A.depth hold", 32'(dep_a), 1);
      end
    end
    cmp("s3 A.result", 32'(res_a), 1);
    cmp("s3 A.depth", 32'(dep_a), 0);

    // "end begin end ": begin ignored while negative
    do_reset();
    sendstr("end");
    cmp("s4 A.underflow", 32'(unf_a), 1);
    cmp("s4 A.depth", 32'(dep_a), 0);
    sendstr(" begin");
    cmp("s4 A.depth begin", 32'(dep_a), 0);
    sendstr(" end ");
    cmp("s4 A.underflow end", 32'(unf_a), 1);
    cmp("s4 A.result end", 32'(res_a), 0);
    cmp("s4 B.underflow end", 32'(unf_b), 1);

    // saturation on the 2-bit instance
    do_reset();
    repeat (3) sendstr("begin ");
    cmp("s5 B.depth 3", 32'(dep_b), 3);
    cmp("s5 B.overflow 3", 32'(ovf_b), 0);
    sendstr("begin ");
    cmp("s5 B.depth 4", 32'(dep_b), 3);
    cmp("s5 B.overflow 4", 32'(ovf_b), 1);
    cmp("s5 A.depth 4", 32'(dep_a), 4);
    repeat (3) sendstr("end ");
    cmp("s5 B.depth end", 32'(dep_b), 0);
    cmp("s5 B.result end", 32'(res_b), 0);
    cmp("s5 B.overflow end", 32'(ovf_b), 1);
    cmp("s5 A.depth end", 32'(dep_a), 1);

    // case sensitivity
    do_reset();
    sendstr("BEGIN ");
    cmp("s6 A.depth", 32'(dep_a), 1);
    cmp("s6 B.depth", 32'(dep_b), 0);
    cmp("s6 B.result", 32'(res_b), 1);

    // separator modes
    do_reset();
    sendstr("begin;e");
    cmp("s7 A.depth", 32'(dep_a), 0);
    cmp("s7 B.depth", 32'(dep_b), 1);
    sendstr("nd;");
    cmp("s7 B.result", 32'(res_b), 1);
    cmp("s7 B.depth", 32'(dep_b), 0);
    do_reset();
    sendstr("en#d");
    cmp("s8 A.underflow", 32'(unf_a), 1);
    cmp("s8 B.underflow", 32'(unf_b), 0);
    send(8'h20);

    // negative floor on the 2-bit instance
    do_reset();
    repeat (5) sendstr("end ");
    cmp("s9 B.underflow", 32'(unf_b), 1);
    cmp("s9 B.depth", 32'(dep_b), 0);
    sendstr("endx ");
    cmp("s9 B.underflow x", 32'(unf_b), 1);

    // asynchronous reset in the middle of a word
    do_reset();
    sendstr("begin begi");
    cmp("s10 A.depth pre", 32'(dep_a), 1);
    reset = 1'b1;
    model_reset();
    #1;
    cmp("s10 A.depth rst", 32'(dep_a), 0);
    cmp("s10 A.result rst", 32'(res_a), 1);
    cmp("s10 A.underflow rst", 32'(unf_a), 0);
    cmp("s10 B.depth rst", 32'(dep_b), 0);
    #2 reset = 1'b0;
    sendstr("n ");
    cmp("s10 A.depth post", 32'(dep_a), 0);
    cmp("s10 A.result post", 32'(res_a), 1);

    @(negedge clk);
    run = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
